core_reset_run_ctrl: RTL and testbench
======================================

// Module: core_reset_run_ctrl
// PURPOSE
//  Synthesizable run controller that drives the reset input of Single_Cycle_Top.
//  Holds the core in reset for a fixed number of cycles, releases it, and then
//  lets it run for a cycle budget or until a halt request.
//  Parks the core back in reset when the run ends, and reports status and the
//  executed cycle count. Sits between board/system reset and the core.
// PARAMETERS
//  HOLD_CYCLES  2   cycles core_rst_n is held low after a (re)start; must be >=1
//  RUN_CYCLES   50  clock edges the core runs; 0 = unlimited (halt_req only)
//  CNT_W        16  width of the hold/run counter and cycle_count
//  AUTO_START   1   1: leave IDLE automatically after rst; 0: wait for start
// PORTS
//  clk          in   1      system clock; the core shares it
//  rst          in   1      asynchronous reset, active-high
//  start        in   1      1-cycle pulse, synchronous to clk: begin or restart a run
//  halt_req     in   1      level, synchronous to clk: end the current run early
//  core_rst_n   out  1      reset to Single_Cycle_Top.rst (active-low, 0 = core in reset)
//  running      out  1      1 while the core is out of reset (state RUN)
//  done         out  1      1 in state DONE; cleared by start or rst
//  cycle_count  out  CNT_W  RUN edges executed in the current or last run
// BEHAVIOUR
//  - All outputs are registered.
//  - rst asserts asynchronously: state=IDLE, core_rst_n=0, running=0, done=0,
//    cycle_count=0, hold counter=0.
//  - rst deasserts synchronously on the next clk edge.
//  - FSM states: IDLE, HOLD, RUN, DONE.
//  - IDLE: core_rst_n=0.
//    - Goes to HOLD on the first edge with (AUTO_START | start).
//  - HOLD: core_rst_n=0.
//    - The hold counter increments on each edge.
//    - On the edge where hold counter+1 == HOLD_CYCLES: go to RUN and set core_rst_n=1.
//    - Net effect: core_rst_n rises exactly HOLD_CYCLES edges after HOLD is entered.
//  - RUN: core_rst_n=1, running=1.
//    - Each edge: cycle_count <= cycle_count+1.
//    - If RUN_CYCLES != 0 and cycle_count+1 == RUN_CYCLES: go to DONE.
//    - Net effect: the core sees exactly RUN_CYCLES rising edges out of reset.
//  - halt_req in RUN: the sampling edge still increments cycle_count, then goes to DONE.
//  - DONE: core_rst_n=0, running=0, done=1, cycle_count frozen.
//    - halt_req is ignored.
//  - start in HOLD, RUN or DONE: restart.
//    - Go to HOLD on that edge.
//    - Clear the hold counter and cycle_count.
//    - Set core_rst_n=0, running=0, done=0.
//  - start and halt_req on the same edge: start wins (restart).
//  - start in IDLE with AUTO_START=1: same as auto-start; no extra effect.
//  - RUN_CYCLES=0: cycle_count saturates at all-ones; the FSM stays in RUN until
//    halt_req or start.
//  - Counter width: the hold counter and cycle_count wrap-free.
//    - Elaboration error if HOLD_CYCLES or RUN_CYCLES >= 2**CNT_W.
//  - rst mid-run: immediate return to the IDLE reset values.
//    - core_rst_n falls asynchronously with rst, with no glitch to 1.
// STRUCTURE
//  - Shared header core_ctrl_defs.vh holds the state encodings ST_IDLE=2'd0,
//    ST_HOLD=2'd1, ST_RUN=2'd2, ST_DONE=2'd3.
//  - One sub-module, sat_counter (CNT_W, clear, enable, saturate at max).
//    - It is instanced twice: hold counter and cycle_count.
//  - The FSM and output registers stay in this module.
// TESTING
//  - Clock period 100 ns. HOLD_CYCLES=2, RUN_CYCLES=50 unless stated otherwise.
//  1 Power-up, AUTO_START=1: release rst.
//    -> core_rst_n=0 for 2 edges after leaving IDLE, then 1 for exactly 50 edges.
//    -> Then done=1, cycle_count=50, core_rst_n=0.
//  2 Early halt: pulse halt_req on the 10th RUN edge.
//    -> done=1, cycle_count=10, core_rst_n=0 on the next cycle.
//  3 Restart from DONE: pulse start.
//    -> done=0, cycle_count=0, HOLD for 2 edges, then a full 50-edge run.
//  4 start and halt_req together in RUN.
//    -> restart (HOLD), done stays 0, cycle_count=0.
//  5 Async rst mid-RUN at count 25.
//    -> core_rst_n=0 and cycle_count=0 immediately, without waiting for clk.
//    -> After release, the sequence of test 1 repeats.
//  6 RUN_CYCLES=0, AUTO_START=0: idle until start.
//    -> Run with no end; halt_req at count 300 -> DONE, cycle_count=300.
//  - Check every output against a reference model each cycle.

Source files
------------

// File: rtl/core_reset_run_ctrl_pkg.sv
// Shared state encodings and elaboration helpers for the core reset/run controller.
package core_reset_run_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_HOLD = 2'd1,
      ST_RUN  = 2'd2,
      ST_DONE = 2'd3
   } run_state_t;

   // True when a non-negative value is representable in an unsigned field of the given width.
   function automatic bit fits_width(int value, int width);
      return (value >= 0) && ((width >= 31) || ((value >> width) == 0));
   endfunction

endpackage

// File: rtl/core_reset_run_ctrl_sat_counter.sv
// Up-counter with synchronous clear that sticks at all-ones instead of wrapping.
module sat_counter #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             en,
   output logic [CNT_W-1:0] q
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         q <= '0;
      end else if (clr) begin
         q <= '0;
      end else if (en && (q != '1)) begin
         q <= q + CNT_W'(1);
      end
   end

endmodule

// File: rtl/core_reset_run_ctrl.sv
// Sequences the core's reset: hold low, release for a cycle budget or until halt, then park.
//  state   | meaning
//  IDLE    | after rst; core in reset, waiting for auto-start or start
//  HOLD    | core in reset for HOLD_CYCLES edges
//  RUN     | core out of reset, cycle_count advancing
//  DONE    | run ended; core parked in reset, cycle_count frozen
module core_reset_run_ctrl
   import core_reset_run_ctrl_pkg::*;
#(
   parameter int HOLD_CYCLES = 2,
   parameter int RUN_CYCLES  = 50,
   parameter int CNT_W       = 16,
   parameter int AUTO_START  = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             halt_req,
   output logic             core_rst_n,
   output logic             running,
   output logic             done,
   output logic [CNT_W-1:0] cycle_count
);

   if (HOLD_CYCLES < 1 || !fits_width(HOLD_CYCLES, CNT_W)) begin : g_bad_hold
      $error("HOLD_CYCLES must be >= 1 and below 2**CNT_W");
   end
   if (!fits_width(RUN_CYCLES, CNT_W)) begin : g_bad_run
      $error("RUN_CYCLES must be below 2**CNT_W");
   end

   // Terminal counts compare against the pre-increment value, so the transition lands on the Nth edge.
   localparam logic [CNT_W-1:0] HOLD_TC     = CNT_W'(HOLD_CYCLES - 1);
   localparam logic [CNT_W-1:0] RUN_TC      = CNT_W'((RUN_CYCLES == 0) ? 0 : RUN_CYCLES - 1);
   localparam bit               RUN_LIMITED = (RUN_CYCLES != 0);
   localparam bit               AUTO        = (AUTO_START != 0);

   run_state_t       st_q, st_d;
   logic             hold_clr, hold_en, run_clr, run_en;
   logic [CNT_W-1:0] hold_q;

   sat_counter #(.CNT_W(CNT_W)) u_hold_cnt (
      .clk (clk),
      .rst (rst),
      .clr (hold_clr),
      .en  (hold_en),
      .q   (hold_q)
   );

   sat_counter #(.CNT_W(CNT_W)) u_run_cnt (
      .clk (clk),
      .rst (rst),
      .clr (run_clr),
      .en  (run_en),
      .q   (cycle_count)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         st_q       <= ST_IDLE;
         core_rst_n <= 1'b0;
         running    <= 1'b0;
         done       <= 1'b0;
      end else begin
         st_q       <= st_d;
         core_rst_n <= (st_d == ST_RUN);
         running    <= (st_d == ST_RUN);
         done       <= (st_d == ST_DONE);
      end
   end

   always_comb begin
      st_d     = st_q;
      hold_clr = 1'b0;
      hold_en  = 1'b0;
      run_clr  = 1'b0;
      run_en   = 1'b0;
      // start outranks halt_req and any terminal count once we have left IDLE.
      if (start && (st_q != ST_IDLE)) begin
         st_d     = ST_HOLD;
         hold_clr = 1'b1;
         run_clr  = 1'b1;
      end else begin
         case (st_q)
            ST_IDLE: begin
               hold_clr = 1'b1;
               run_clr  = 1'b1;
               if (AUTO || start) st_d = ST_HOLD;
            end
            ST_HOLD: begin
               hold_en = 1'b1;
               if (hold_q == HOLD_TC) st_d = ST_RUN;
            end
            ST_RUN: begin
               run_en = 1'b1;
               if (halt_req || (RUN_LIMITED && (cycle_count == RUN_TC))) st_d = ST_DONE;
            end
            ST_DONE: ;
            default: st_d = ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_core_reset_run_ctrl.sv
// Bench for core_reset_run_ctrl: two instances (auto/limited and manual/unlimited) against a phase model.
module tb_core_reset_run_ctrl;

   localparam int H   = 2;
   localparam int RA  = 50;
   localparam int CW  = 16;
   localparam int SAT = (1 << CW) - 1;

   logic clk = 1'b0;
   always #50 clk = ~clk;

   logic          rst_a, start_a, halt_a, crn_a, run_a, done_a;
   logic [CW-1:0] cnt_a;
   logic          rst_b, start_b, halt_b, crn_b, run_b, done_b;
   logic [CW-1:0] cnt_b;

   core_reset_run_ctrl #(.HOLD_CYCLES(2), .RUN_CYCLES(50), .CNT_W(16), .AUTO_START(1)) dut_a (
      .clk(clk), .rst(rst_a), .start(start_a), .halt_req(halt_a),
      .core_rst_n(crn_a), .running(run_a), .done(done_a), .cycle_count(cnt_a));

   core_reset_run_ctrl #(.HOLD_CYCLES(2), .RUN_CYCLES(0), .CNT_W(16), .AUTO_START(0)) dut_b (
      .clk(clk), .rst(rst_b), .start(start_b), .halt_req(halt_b),
      .core_rst_n(crn_b), .running(run_b), .done(done_b), .cycle_count(cnt_b));

   // started: left IDLE; elapsed: edges since the last (re)start; ran: run edges; finished: run over
   typedef struct {
      bit started;
      int elapsed;
      int ran;
      bit finished;
   } model_t;

   model_t ma, mb;
   int     n_cmp = 0;
   int     n_bad = 0;

   function automatic model_t model_step(model_t m, bit r, bit s, bit h, int run_len, bit auto_go);
      model_t n = m;
      if (r) begin
         n.started = 1'b0; n.elapsed = 0; n.ran = 0; n.finished = 1'b0;
      end else if (m.started && s) begin
         n.elapsed = 0; n.ran = 0; n.finished = 1'b0;
      end else if (!m.started) begin
         if (auto_go || s) begin
            n.started = 1'b1; n.elapsed = 0;
         end
      end else if (m.elapsed < H) begin
         n.elapsed = m.elapsed + 1;
      end else if (!m.finished) begin
         n.ran = (m.ran < SAT) ? m.ran + 1 : SAT;
         if (h || (run_len != 0 && n.ran == run_len)) n.finished = 1'b1;
      end
      return n;
   endfunction

   function automatic logic [CW+2:0] model_out(model_t m);
      logic in_run;
      in_run = m.started && (m.elapsed >= H) && !m.finished;
      return {in_run, in_run, m.finished, CW'(m.ran)};
   endfunction

   task automatic tick(input bit sa, input bit ha, input bit sb, input bit hb);
      start_a = sa; halt_a = ha; start_b = sb; halt_b = hb;
      @(posedge clk);
      ma = model_step(ma, rst_a, sa, ha, RA, 1'b1);
      mb = model_step(mb, rst_b, sb, hb, 0, 1'b0);
      #1;
      start_a = 1'b0; halt_a = 1'b0; start_b = 1'b0; halt_b = 1'b0;
   endtask

   task automatic test_reset();
      rst_a = 1'b1; rst_b = 1'b1;
      start_a = 1'b0; halt_a = 1'b0; start_b = 1'b0; halt_b = 1'b0;
      #30;
      n_cmp++;
      if ({crn_a, run_a, done_a, cnt_a} !== 19'h0) begin
         n_bad++; $display("FAIL reset_async_a got %h want 0", {crn_a, run_a, done_a, cnt_a});
      end
      repeat (2) tick(1'b0, 1'b0, 1'b0, 1'b0);
      n_cmp++;
      if ({crn_a, run_a, done_a, cnt_a} !== 19'h0) begin
         n_bad++; $display("FAIL reset_held_a got %h want 0", {crn_a, run_a, done_a, cnt_a});
      end
      n_cmp++;
      if ({crn_b, run_b, done_b, cnt_b} !== 19'h0) begin
         n_bad++; $display("FAIL reset_held_b got %h want 0", {crn_b, run_b, done_b, cnt_b});
      end
      rst_a = 1'b0; rst_b = 1'b0;
   endtask

   task automatic test_power_up();
      int ones = 0;
      for (int n = 1; n <= 56; n++) begin
         tick(1'b0, 1'b0, 1'b0, 1'b0);
         if (crn_a) ones++;
         n_cmp++;
         if ({crn_a, run_a, done_a, cnt_a} !== model_out(ma)) begin
            n_bad++; $display("FAIL powerup_cycle t=%0t got %h want %h", $time, {crn_a, run_a, done_a, cnt_a}, model_out(ma));
         end
         if (n == 2) begin
            n_cmp++;
            if (crn_a !== 1'b0) begin n_bad++; $display("FAIL powerup_hold got %b want 0", crn_a); end
         end
         if (n == 3) begin
            n_cmp++;
            if (crn_a !== 1'b1) begin n_bad++; $display("FAIL powerup_release got %b want 1", crn_a); end
         end
         if (n == 53) begin
            n_cmp++;
            if ({done_a, cnt_a, crn_a} !== {1'b1, 16'd50, 1'b0}) begin
               n_bad++; $display("FAIL powerup_done done=%b cnt=%0d crn=%b want 1/50/0", done_a, cnt_a, crn_a);
            end
         end
      end
      n_cmp++;
      if (ones != RA) begin n_bad++; $display("FAIL powerup_run_edges got %0d want %0d", ones, RA); end
   endtask

   task automatic test_restart_from_done();
      int ones = 0;
      tick(1'b1, 1'b0, 1'b0, 1'b0);
      n_cmp++;
      if ({crn_a, run_a, done_a, cnt_a} !== 19'h0) begin
         n_bad++; $display("FAIL restart_clear got %h want 0", {crn_a, run_a, done_a, cnt_a});
      end
      for (int n = 1; n <= 53; n++) begin
         tick(1'b0, 1'b0, 1'b0, 1'b0);
         if (crn_a) ones++;
         n_cmp++;
         if ({crn_a, run_a, done_a, cnt_a} !== model_out(ma)) begin
            n_bad++; $display("FAIL restart_cycle t=%0t got %h want %h", $time, {crn_a, run_a, done_a, cnt_a}, model_out(ma));
         end
      end
      n_cmp++;
      if (ones != RA || done_a !== 1'b1 || cnt_a !== 16'd50) begin
         n_bad++; $display("FAIL restart_full_run edges=%0d done=%b cnt=%0d want 50/1/50", ones, done_a, cnt_a);
      end
   endtask

   task automatic test_early_halt();
      tick(1'b1, 1'b0, 1'b0, 1'b0);
      repeat (11) begin
         tick(1'b0, 1'b0, 1'b0, 1'b0);
         n_cmp++;
         if ({crn_a, run_a, done_a, cnt_a} !== model_out(ma)) begin
            n_bad++; $display("FAIL halt_cycle t=%0t got %h want %h", $time, {crn_a, run_a, done_a, cnt_a}, model_out(ma));
         end
      end
      n_cmp++;
      if (cnt_a !== 16'd9 || run_a !== 1'b1) begin
         n_bad++; $display("FAIL halt_pre cnt=%0d running=%b want 9/1", cnt_a, run_a);
      end
      tick(1'b0, 1'b1, 1'b0, 1'b0);
      n_cmp++;
      if ({done_a, cnt_a, crn_a, run_a} !== {1'b1, 16'd10, 1'b0, 1'b0}) begin
         n_bad++; $display("FAIL halt_done done=%b cnt=%0d crn=%b run=%b want 1/10/0/0", done_a, cnt_a, crn_a, run_a);
      end
      repeat (3) tick(1'b0, 1'b1, 1'b0, 1'b0);
      n_cmp++;
      if ({done_a, cnt_a, crn_a} !== {1'b1, 16'd10, 1'b0}) begin
         n_bad++; $display("FAIL halt_in_done done=%b cnt=%0d crn=%b want 1/10/0", done_a, cnt_a, crn_a);
      end
   endtask

   task automatic test_start_halt_together();
      tick(1'b1, 1'b0, 1'b0, 1'b0);
      repeat (7) tick(1'b0, 1'b0, 1'b0, 1'b0);
      n_cmp++;
      if (cnt_a !== 16'd5) begin n_bad++; $display("FAIL both_pre cnt=%0d want 5", cnt_a); end
      tick(1'b1, 1'b1, 1'b0, 1'b0);
      n_cmp++;
      if ({crn_a, run_a, done_a, cnt_a} !== 19'h0) begin
         n_bad++; $display("FAIL both_restart got %h want 0", {crn_a, run_a, done_a, cnt_a});
      end
      repeat (4) begin
         tick(1'b0, 1'b0, 1'b0, 1'b0);
         n_cmp++;
         if ({crn_a, run_a, done_a, cnt_a} !== model_out(ma)) begin
            n_bad++; $display("FAIL both_cycle t=%0t got %h want %h", $time, {crn_a, run_a, done_a, cnt_a}, model_out(ma));
         end
      end
   endtask

   task automatic test_async_reset();
      tick(1'b1, 1'b0, 1'b0, 1'b0);
      repeat (27) tick(1'b0, 1'b0, 1'b0, 1'b0);
      n_cmp++;
      if (cnt_a !== 16'd25 || crn_a !== 1'b1) begin
         n_bad++; $display("FAIL arst_pre cnt=%0d crn=%b want 25/1", cnt_a, crn_a);
      end
      #20;
      rst_a = 1'b1;
      ma = '{default: 0};
      #1;
      n_cmp++;
      if ({crn_a, run_a, done_a, cnt_a} !== 19'h0) begin
         n_bad++; $display("FAIL arst_immediate got %h want 0", {crn_a, run_a, done_a, cnt_a});
      end
      repeat (2) begin
         tick(1'b0, 1'b0, 1'b0, 1'b0);
         n_cmp++;
         if ({crn_a, run_a, done_a, cnt_a} !== model_out(ma)) begin
            n_bad++; $display("FAIL arst_held t=%0t got %h want %h", $time, {crn_a, run_a, done_a, cnt_a}, model_out(ma));
         end
      end
      rst_a = 1'b0;
      test_power_up();
   endtask

   task automatic test_unlimited();
      repeat (5) begin
         tick(1'b0, 1'b0, 1'b0, 1'b0);
         n_cmp++;
         if ({crn_b, run_b, done_b, cnt_b} !== 19'h0) begin
            n_bad++; $display("FAIL unl_idle got %h want 0", {crn_b, run_b, done_b, cnt_b});
         end
      end
      tick(1'b0, 1'b0, 1'b1, 1'b0);
      repeat (301) begin
         tick(1'b0, 1'b0, 1'b0, 1'b0);
         n_cmp++;
         if ({crn_b, run_b, done_b, cnt_b} !== model_out(mb)) begin
            n_bad++; $display("FAIL unl_cycle t=%0t got %h want %h", $time, {crn_b, run_b, done_b, cnt_b}, model_out(mb));
         end
      end
      n_cmp++;
      if (cnt_b !== 16'd299 || run_b !== 1'b1) begin
         n_bad++; $display("FAIL unl_pre cnt=%0d running=%b want 299/1", cnt_b, run_b);
      end
      tick(1'b0, 1'b0, 1'b0, 1'b1);
      n_cmp++;
      if ({done_b, cnt_b, crn_b} !== {1'b1, 16'd300, 1'b0}) begin
         n_bad++; $display("FAIL unl_halt done=%b cnt=%0d crn=%b want 1/300/0", done_b, cnt_b, crn_b);
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 600; i++) begin
         tick($urandom_range(0, 39) == 0, $urandom_range(0, 14) == 0,
              $urandom_range(0, 99) == 0, $urandom_range(0, 29) == 0);
         n_cmp++;
         if ({crn_a, run_a, done_a, cnt_a} !== model_out(ma)) begin
            n_bad++; $display("FAIL rand_a t=%0t got %h want %h", $time, {crn_a, run_a, done_a, cnt_a}, model_out(ma));
         end
         n_cmp++;
         if ({crn_b, run_b, done_b, cnt_b} !== model_out(mb)) begin
            n_bad++; $display("FAIL rand_b t=%0t got %h want %h", $time, {crn_b, run_b, done_b, cnt_b}, model_out(mb));
         end
      end
   endtask

   initial begin
      ma = '{default: 0};
      mb = '{default: 0};
      test_reset();
      test_power_up();
      test_restart_from_done();
      test_early_halt();
      test_start_halt_together();
      test_async_reset();
      test_unlimited();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
